// File: rtl/fp_mul_pkg.sv
// Shared definitions for the floating-point multiplier.
// Holds the mantissa controller state encoding and default widths.
package fp_mul_pkg;

  localparam int MANT_W = 24;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/csa_row.sv
// One row of N 3:2 carry-save cells, purely combinational.
// Ports: x, y, z addends in; s per-bit sum, c per-bit carry (unshifted).
module csa_row #(
  parameter int N = 48
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic [N-1:0] z,
  output logic [N-1:0] s,
  output logic [N-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/mant_mul_seq.sv
// Iterative unsigned mantissa multiplier: one CSA row per cycle, one final add.
// Ports: in_valid/in_ready/a/b operand side; out_valid/out_ready/product result side; busy.
module mant_mul_seq
  import fp_mul_pkg::*;
#(
  parameter int WIDTH = MANT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  state_t state;
  state_t state_nx;

  logic [PW-1:0]    a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [PW-1:0]    sum;
  logic [PW-1:0]    carry;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    s;
  logic [PW-1:0]    c;
  logic             accept;
  logic             last;

  assign accept = in_valid && (state == IDLE);
  // No set bits above bit 0 remain: this is the final partial product.
  assign last   = (b_sh[WIDTH-1:1] == '0);
  assign pp     = b_sh[0] ? a_sh : '0;

  csa_row #(
    .N(PW)
  ) u_csa (
    .x(sum),
    .y(carry),
    .z(pp),
    .s(s),
    .c(c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (accept) state_nx = (b == '0) ? RESOLVE : ACCUM;
      end
      ACCUM: begin
        if (last) state_nx = RESOLVE;
      end
      RESOLVE: state_nx = DONE;
      DONE: begin
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      sum       <= '0;
      carry     <= '0;
      product   <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh  <= {{WIDTH{1'b0}}, a};
            b_sh  <= b;
            sum   <= '0;
            carry <= '0;
          end
        end
        ACCUM: begin
          sum   <= s;
          // Top carry bit is dropped: the exact product fits in PW bits.
          carry <= c << 1;
          a_sh  <= a_sh << 1;
          b_sh  <= b_sh >> 1;
        end
        RESOLVE: begin
          product   <= sum + carry;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_mant_mul_seq.sv
// Self-checking bench for mant_mul_seq.
// Directed cases then randomized operands against an arithmetic reference.
module tb_mant_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] a;
  logic [23:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [47:0] product;
  logic        busy;

  int n_chk  = 0;
  int n_fail = 0;

  mant_mul_seq dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a(a),
    .b(b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .product(product),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ref_lat(input logic [23:0] bv);
    int m;
    m = -1;
    for (int i = 0; i < 24; i++) if (bv[i]) m = i;
    return (m < 0) ? 1 : m + 2;
  endfunction

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_op(input logic [23:0] ta, input logic [23:0] tb_v,
                       input int gap, input bit pre_rdy, input int hold);
    int n;
    logic [47:0] exp_p;
    exp_p = 48'(ta) * 48'(tb_v);
    repeat (gap) @(negedge clk);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 24'($urandom);
    b        = 24'($urandom);
    chk("in_ready_busy", 64'(in_ready), 64'd0);
    if (pre_rdy) out_ready = 1'b1;
    wait_valid(n);
    chk("latency", 64'(n), 64'(ref_lat(tb_v)));
    chk("product", 64'(product), 64'(exp_p));
    if (!pre_rdy) begin
      repeat (hold) begin
        @(negedge clk);
        chk("hold_product", 64'(product), 64'(exp_p));
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int n;
    int sh;
    logic [23:0] ra;
    logic [23:0] rb;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op(24'd3, 24'd5, 1, 1'b0, 2);
    do_op(24'hFFFFFF, 24'hFFFFFF, 0, 1'b0, 0);
    do_op(24'h800000, 24'd0, 0, 1'b0, 0);
    do_op(24'd0, 24'h800000, 0, 1'b1, 0);

    // Backpressure with a competing request held during DONE.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 24'h123456;
    b        = 24'h000002;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    chk("bp_latency", 64'(n), 64'd3);
    in_valid = 1'b1;
    a        = 24'h000011;
    b        = 24'h000003;
    repeat (10) begin
      @(negedge clk);
      chk("bp_product", 64'(product), 64'h2468AC);
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept2", 64'(in_ready), 64'd0);
    wait_valid(n);
    chk("bp2_latency", 64'(n), 64'd3);
    chk("bp2_product", 64'(product), 64'h33);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset in the middle of accumulation.
    in_valid = 1'b1;
    a        = 24'hFFFFFF;
    b        = 24'hFFFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_product", 64'(product), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(24'd7, 24'd6, 0, 1'b0, 1);

    for (int i = 0; i < 1000; i++) begin
      ra = 24'($urandom);
      sh = $urandom_range(0, 24);
      rb = 24'($urandom) >> sh;
      do_op(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
